// File: rtl/nios_st_packet_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nios_st_packet_fifo
// Description : Avalon-ST FIFO carrying SOP/EOP sideband with fill/packet
//               status, synchronous flush and optional store-and-forward.
// Revision    : 1.0 - initial release
// ============================================================================
module nios_st_packet_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter bit PACKET_MODE  = 1'b0,
    parameter int ALMOST_FULL  = 12,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_startofpacket,
    input  logic                  in_endofpacket,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int                c_MEM_W = DATA_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AF    = (ADDR_WIDTH+1)'(ALMOST_FULL);
    localparam logic [ADDR_WIDTH:0] c_AE    = (ADDR_WIDTH+1)'(ALMOST_EMPTY);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);

    logic [c_MEM_W-1:0]    mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   fill_q, fill_d;
    logic [ADDR_WIDTH:0]   pkt_q, pkt_d;
    logic [ADDR_WIDTH:0]   mem_pkt_q, mem_pkt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_sop_q, out_sop_d;
    logic                  out_eop_q, out_eop_d;
    logic                  cont_q, cont_d;

    logic                  w_accept;
    logic                  w_deliver;
    logic                  w_load;
    logic                  w_release_ok;
    logic                  w_escape;
    logic [ADDR_WIDTH:0]   w_mem_cnt;
    logic [c_MEM_W-1:0]    w_head;
    logic                  w_head_eop;
    logic                  w_head_sop;
    logic [DATA_WIDTH-1:0] w_head_data;

    assign in_ready     = (fill_q < c_DEPTH) & ~flush;
    assign w_accept     = in_valid & in_ready;
    assign w_deliver    = out_valid_q & out_ready & ~flush;

    // fill_level includes the beat parked in the output register.
    assign w_mem_cnt    = fill_q - {{ADDR_WIDTH{1'b0}}, out_valid_q};
    assign w_head       = mem_q[rd_ptr_q];
    assign w_head_sop   = w_head[DATA_WIDTH+1];
    assign w_head_eop   = w_head[DATA_WIDTH];
    assign w_head_data  = w_head[DATA_WIDTH-1:0];

    // A full buffer with no complete packet can never see its EOP arrive,
    // so the head packet is let through as cut-through instead.
    assign w_escape     = (fill_q == c_DEPTH) && (pkt_q == '0);
    assign w_release_ok = !PACKET_MODE || (mem_pkt_q != '0) || cont_q || w_escape;
    assign w_load       = ~flush && (w_mem_cnt != '0) && w_release_ok
                          && (~out_valid_q || out_ready);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[wr_ptr_q] <= {in_startofpacket, in_endofpacket, in_data};
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        pkt_d       = pkt_q;
        mem_pkt_d   = mem_pkt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        cont_d      = cont_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fill_d      = '0;
            pkt_d       = '0;
            mem_pkt_d   = '0;
            out_valid_d = 1'b0;
            cont_d      = 1'b0;
        end else begin
            if (w_accept) begin
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end
            fill_d    = fill_q
                        + {{ADDR_WIDTH{1'b0}}, w_accept}
                        - {{ADDR_WIDTH{1'b0}}, w_deliver};
            pkt_d     = pkt_q
                        + {{ADDR_WIDTH{1'b0}}, w_accept & in_endofpacket}
                        - {{ADDR_WIDTH{1'b0}}, w_deliver & out_eop_q};
            mem_pkt_d = mem_pkt_q
                        + {{ADDR_WIDTH{1'b0}}, w_accept & in_endofpacket}
                        - {{ADDR_WIDTH{1'b0}}, w_load & w_head_eop};

            if (w_load) begin
                rd_ptr_d    = rd_ptr_q + c_PTR_ONE;
                out_valid_d = 1'b1;
                out_data_d  = w_head_data;
                out_sop_d   = w_head_sop;
                out_eop_d   = w_head_eop;
                // Keep streaming the rest of this packet once it has started.
                cont_d      = ~w_head_eop;
            end else if (w_deliver) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            pkt_q       <= '0;
            mem_pkt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            cont_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            pkt_q       <= pkt_d;
            mem_pkt_q   <= mem_pkt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            cont_q      <= cont_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign fill_level        = fill_q;
    assign pkt_count         = pkt_q;
    assign almost_full       = (fill_q >= c_AF);
    assign almost_empty      = (fill_q <= c_AE);

endmodule
`default_nettype wire

// File: tb/tb_nios_st_packet_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_nios_st_packet_fifo
// Description : Directed + random scoreboard bench for cut-through (inst 0)
//               and store-and-forward (inst 1) FIFO instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_st_packet_fifo;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [1:0]  iv, isop, ieop, ordy;
    logic [31:0] id [2];
    logic [1:0]  ir, ov, osop, oeop, af, ae;
    logic [31:0] od [2];
    logic [4:0]  fl [2];
    logic [4:0]  pc [2];

    int          checks;
    int          errors;
    logic [33:0] sb [$];
    int          mfill;
    int          mpkt;
    int          ndel;
    logic        hold_v;
    logic [33:0] hold_b;
    logic        last_acc;

    nios_st_packet_fifo #(.PACKET_MODE(1'b0)) dut_ct (
        .clk(clk), .reset(reset), .flush(flush),
        .in_ready(ir[0]), .in_valid(iv[0]), .in_data(id[0]),
        .in_startofpacket(isop[0]), .in_endofpacket(ieop[0]),
        .out_ready(ordy[0]), .out_valid(ov[0]), .out_data(od[0]),
        .out_startofpacket(osop[0]), .out_endofpacket(oeop[0]),
        .fill_level(fl[0]), .pkt_count(pc[0]),
        .almost_full(af[0]), .almost_empty(ae[0])
    );

    nios_st_packet_fifo #(.PACKET_MODE(1'b1)) dut_sf (
        .clk(clk), .reset(reset), .flush(flush),
        .in_ready(ir[1]), .in_valid(iv[1]), .in_data(id[1]),
        .in_startofpacket(isop[1]), .in_endofpacket(ieop[1]),
        .out_ready(ordy[1]), .out_valid(ov[1]), .out_data(od[1]),
        .out_startofpacket(osop[1]), .out_endofpacket(oeop[1]),
        .fill_level(fl[1]), .pkt_count(pc[1]),
        .almost_full(af[1]), .almost_empty(ae[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        mfill  = 0;
        mpkt   = 0;
        hold_v = 1'b0;
    endtask

    // One clock of instance m: sample and score at negedge, return #1 after posedge.
    task automatic cycle(input int m);
        logic        acc, del;
        logic [33:0] cur, exp_b;
        @(negedge clk);
        cur = {osop[m], oeop[m], od[m]};
        if (hold_v) chk("hold_stable", {ov[m], cur}, {1'b1, hold_b});
        chk("fill_level", fl[m], mfill);
        chk("pkt_count", pc[m], mpkt);
        chk("in_ready", ir[m], (mfill < 16) && !flush);
        chk("almost_full", af[m], mfill >= 12);
        chk("almost_empty", ae[m], mfill <= 2);
        acc = iv[m] & ir[m];
        del = ov[m] & ordy[m];
        if (flush) begin
            model_clear();
            acc = 1'b0;
        end else begin
            if (del) begin
                chk("beat_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    chk("beat", cur, exp_b);
                    if (exp_b[32]) mpkt--;
                end
                mfill--;
                ndel++;
            end
            if (acc) begin
                sb.push_back({isop[m], ieop[m], id[m]});
                mfill++;
                if (ieop[m]) mpkt++;
            end
            hold_v = ov[m] & ~ordy[m];
            hold_b = cur;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int m, input int budget);
        int n;
        iv[m]   = 1'b0;
        ordy[m] = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cycle(m);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, maxfill, d0;
        checks = 0; errors = 0; ndel = 0; last_acc = 1'b0;
        model_clear();
        reset = 1'b1; flush = 1'b0;
        iv = '0; isop = '0; ieop = '0; ordy = '0;
        id[0] = '0; id[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int m = 0; m < 2; m++) begin
            chk("rst_out_valid", ov[m], 1'b0);
            chk("rst_out_data", {osop[m], oeop[m], od[m]}, 34'd0);
            chk("rst_fill", fl[m], 5'd0);
            chk("rst_pkt", pc[m], 5'd0);
            chk("rst_almost_empty", ae[m], 1'b1);
            chk("rst_almost_full", af[m], 1'b0);
            chk("rst_in_ready", ir[m], 1'b1);
        end

        // Fill cut-through instance to 16 with sink stalled.
        ordy[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            iv[0] = 1'b1; id[0] = i;
            cycle(0);
            if (i == 0) chk("latency_edge_k", ov[0], 1'b0);
            if (i == 1) chk("latency_edge_k1", ov[0], 1'b1);
        end
        id[0] = 32'h99;
        cycle(0);
        chk("full_level", fl[0], 5'd16);
        chk("full_in_ready", ir[0], 1'b0);
        drain(0, 40);
        chk("drained_level", fl[0], 5'd0);

        // Full-rate streaming.
        ordy[0] = 1'b1;
        d0 = ndel;
        for (int i = 0; i < 100; i++) begin
            iv[0] = 1'b1; id[0] = 1000 + i;
            cycle(0);
            if (i >= 2) begin
                chk("stream_valid", ov[0], 1'b1);
                chk("stream_level", fl[0], 5'd2);
            end
        end
        chk("stream_throughput", ndel - d0, 98);
        drain(0, 20);

        // Store-and-forward: 5-beat packet gated until EOP stored.
        ordy[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            iv[1] = 1'b1; id[1] = 200 + i;
            isop[1] = (i == 0); ieop[1] = (i == 4);
            cycle(1);
            chk("saf_gated", ov[1], 1'b0);
        end
        chk("saf_pkt_one", pc[1], 5'd1);
        iv[1] = 1'b0; isop[1] = 1'b0; ieop[1] = 1'b0;
        cycle(1);
        chk("saf_released", ov[1], 1'b1);
        drain(1, 20);
        chk("saf_pkt_zero", pc[1], 5'd0);

        // Store-and-forward: 20-beat packet forces the deadlock escape.
        sent = 0; maxfill = 0; d0 = ndel;
        for (int n = 0; n < 200 && sent < 20; n++) begin
            iv[1] = 1'b1; id[1] = 300 + sent;
            isop[1] = (sent == 0); ieop[1] = (sent == 19);
            cycle(1);
            if (last_acc) sent++;
            if (int'(fl[1]) > maxfill) maxfill = int'(fl[1]);
        end
        isop[1] = 1'b0; ieop[1] = 1'b0;
        chk("escape_sent", sent, 20);
        chk("escape_reached_full", maxfill, 16);
        drain(1, 60);
        chk("escape_delivered", ndel - d0, 20);

        // Flush with 7 beats stored, concurrent accept/deliver ignored.
        ordy[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            iv[0] = 1'b1; id[0] = 400 + i; ieop[0] = (i == 6);
            cycle(0);
        end
        chk("preflush_level", fl[0], 5'd7);
        chk("preflush_pkt", pc[0], 5'd1);
        flush = 1'b1; ordy[0] = 1'b1; ieop[0] = 1'b0; id[0] = 32'h777;
        cycle(0);
        flush = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b0;
        chk("flush_level", fl[0], 5'd0);
        chk("flush_pkt", pc[0], 5'd0);
        chk("flush_valid", ov[0], 1'b0);
        cycle(0);
        chk("flush_stays_empty", ov[0], 1'b0);

        // Async reset pulsed mid-packet.
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; id[0] = 500 + i; isop[0] = (i == 0);
            cycle(0);
        end
        iv[0] = 1'b0; isop[0] = 1'b0;
        chk("prereset_valid", ov[0], 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", ov[0], 1'b0);
        chk("async_data", {osop[0], oeop[0], od[0]}, 34'd0);
        chk("async_level", fl[0], 5'd0);
        reset = 1'b0;
        model_clear();
        ordy[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iv[1] = 1'b1; id[1] = 600 + i;
            isop[1] = (i == 0); ieop[1] = (i == 3);
            cycle(1);
        end
        isop[1] = 1'b0; ieop[1] = 1'b0;
        drain(1, 20);

        // Random traffic on both modes, closed with an EOP beat.
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 320; c++) begin
                iv[m]   = ($urandom_range(0, 3) != 0);
                ordy[m] = ($urandom_range(0, 2) != 0);
                id[m]   = $urandom;
                isop[m] = ($urandom_range(0, 3) == 0);
                ieop[m] = ($urandom_range(0, 3) == 0);
                cycle(m);
            end
            ordy[m] = 1'b1; iv[m] = 1'b1; ieop[m] = 1'b1; id[m] = 32'hE0F;
            for (int n = 0; n < 40; n++) begin
                cycle(m);
                if (last_acc) break;
            end
            ieop[m] = 1'b0; isop[m] = 1'b0;
            drain(m, 100);
            ordy[m] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
